led_pattern_gen: RTL

Upstream pattern source for the 4-bit LED output register on the Pynq-Z2 board. It debounces two raw push-buttons and runs a mode state machine with a tick prescaler. It drives a 4-bit pattern `d` with a one-cycle load strobe `en` straight into the register's `d`/`en` pins. The register has no reset, so this block also issues the initial load after reset.

---
 rtl/led_pattern_gen.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: debounced mode/pause buttons drive a 4-bit LED pattern generator with a tick prescaler.
// Latency: raw button edge to LED load is DEBOUNCE_CYCLES+3 cycles; tick to load is 1 cycle; init load is 1 cycle after reset release.
// Backpressure: none; the LED register always accepts a load, so en is a fire-and-forget one-cycle strobe.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   btn_mode          raw asynchronous button, press advances the mode
//   btn_pause         raw asynchronous button, press toggles pause
//   en, d[3:0]        one-cycle load strobe and registered pattern for the LED register
//   mode[1:0], paused status outputs
module led_pattern_gen #(
  parameter int TICK_DIV        = 31_250_000,
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_pause,
  output logic       en,
  output logic [3:0] d,
  output logic [1:0] mode,
  output logic       paused
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_COUNT  = 2'b00,
    S_SHIFT  = 2'b01,
    S_BOUNCE = 2'b10,
    S_BLINK  = 2'b11
  } mode_t;

  // ---------------------------------------------------------------
  // Button path: bit 0 = mode button, bit 1 = pause button
  // ---------------------------------------------------------------
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_db;
  logic [1:0]    r_db_d;
  logic [CW-1:0] r_db_cnt [2];
  logic [1:0]    w_btn_ev;
  logic          w_mode_ev;
  logic          w_pause_ev;

  assign w_raw = {btn_pause, btn_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < 2; i++) begin
        // The counter only runs while the synchronized level disagrees with
        // the accepted level; the Nth consecutive disagreement commits it.
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Press events only; releases are ignored.
  assign w_btn_ev   = r_db & ~r_db_d;
  assign w_mode_ev  = w_btn_ev[0];
  assign w_pause_ev = w_btn_ev[1];

  // ---------------------------------------------------------------
  // Mode FSM, prescaler and pattern register
  // ---------------------------------------------------------------
  mode_t         r_state;
  mode_t         w_state_nxt;
  logic [3:0]    r_d;
  logic [3:0]    w_d_nxt;
  logic          r_en;
  logic          w_en_nxt;
  logic          r_paused;
  logic          w_paused_nxt;
  logic          r_dir;          // BOUNCE direction: 0 = left, 1 = right
  logic          w_dir_nxt;
  logic          r_init;         // pending post-reset load for the LED register
  logic          w_init_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          w_tick;
  logic [3:0]    w_step_d;
  logic          w_step_dir;
  mode_t         w_adv_state;
  logic [3:0]    w_adv_seed;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  // Next pattern within the current mode.
  always_comb begin
    w_step_d   = r_d;
    w_step_dir = r_dir;
    case (r_state)
      S_COUNT:  w_step_d = r_d + 4'd1;
      S_SHIFT:  w_step_d = {r_d[2:0], r_d[3]};
      S_BOUNCE: begin
        // Direction flips as the endpoint is entered, so the endpoint is
        // shown once and the following step already moves away from it.
        if (!r_dir) begin
          w_step_d = {r_d[2:0], 1'b0};
          if (r_d == 4'b0100) w_step_dir = 1'b1;
        end else begin
          w_step_d = {1'b0, r_d[3:1]};
          if (r_d == 4'b0010) w_step_dir = 1'b0;
        end
      end
      S_BLINK:  w_step_d = ~r_d;
    endcase
  end

  // Mode advance and the seed of the mode being entered.
  always_comb begin
    w_adv_state = S_COUNT;
    w_adv_seed  = 4'b0000;
    case (r_state)
      S_COUNT:  begin w_adv_state = S_SHIFT;  w_adv_seed = 4'b0001; end
      S_SHIFT:  begin w_adv_state = S_BOUNCE; w_adv_seed = 4'b0001; end
      S_BOUNCE: begin w_adv_state = S_BLINK;  w_adv_seed = 4'b0000; end
      S_BLINK:  begin w_adv_state = S_COUNT;  w_adv_seed = 4'b0000; end
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_d_nxt      = r_d;
    w_en_nxt     = 1'b0;
    w_paused_nxt = r_paused;
    w_dir_nxt    = r_dir;
    w_init_nxt   = 1'b0;
    w_presc_nxt  = w_tick ? '0 : r_presc + PW'(1);

    if (r_init) begin
      // Init load: prescaler restarts so the first step is a full period away.
      w_d_nxt     = 4'b0000;
      w_en_nxt    = 1'b1;
      w_presc_nxt = '0;
    end else begin
      if (w_pause_ev) w_paused_nxt = ~r_paused;
      // Mode load wins over a same-cycle tick; the tick uses the
      // pre-toggle pause state.
      if (w_mode_ev) begin
        w_state_nxt = w_adv_state;
        w_d_nxt     = w_adv_seed;
        w_dir_nxt   = 1'b0;
        w_en_nxt    = 1'b1;
        w_presc_nxt = '0;
      end else if (w_tick && !r_paused) begin
        w_d_nxt   = w_step_d;
        w_dir_nxt = w_step_dir;
        w_en_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_COUNT;
      r_d      <= 4'b0000;
      r_en     <= 1'b0;
      r_paused <= 1'b0;
      r_dir    <= 1'b0;
      r_init   <= 1'b1;
      r_presc  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_d      <= w_d_nxt;
      r_en     <= w_en_nxt;
      r_paused <= w_paused_nxt;
      r_dir    <= w_dir_nxt;
      r_init   <= w_init_nxt;
      r_presc  <= w_presc_nxt;
    end
  end

  assign en     = r_en;
  assign d      = r_d;
  assign mode   = r_state;
  assign paused = r_paused;

endmodule
